// File: rtl/brick_field.sv
// Brick wall: latches ball hit events into a per-brick level table and renders the
// two-row wall through a 2-cycle pixel pipeline. Optional macro HIT_FLASH_EN adds hit flashing.
module brick_field #(
  parameter int NUM_BLOCKS      = 10,
  parameter int BLOCKS_PER_ROW  = 5,
  parameter int BLOCK_SPACING_X = 40,
  parameter int BLOCK_WIDTH     = 80,
  parameter int BLOCK_HEIGHT    = 30,
  parameter int FIRST_ROW_Y     = 40,
  parameter int SECOND_ROW_Y    = 90,
  parameter int FLASH_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       erase_enable,
  input  logic [5:0] e_pos,
  input  logic [1:0] active_data,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_tick,
  output logic [7:0] rgb,
  output logic       brick_pixel,
  output logic [3:0] blocks_left,
  output logic       all_cleared
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);

  logic [1:0]       level_q [NUM_BLOCKS];
  logic [1:0]       level_d [NUM_BLOCKS];
  logic [3:0]       blocks_left_q, blocks_left_d;
  logic             all_cleared_q, all_cleared_d;
  logic             s1_inside_q, s1_inside_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_video_q, s1_video_d;
  logic [7:0]       rgb_q, rgb_d;
  logic             brick_pixel_q, brick_pixel_d;

  logic [10:0]      px, py;
  logic             row_hit, row_sel, col_hit;
  logic [IDX_W-1:0] col_sel;
  logic [1:0]       rd_level;

  assign px = {1'b0, pixel_x};
  assign py = {1'b0, pixel_y};

  // Levels only ever rise, so a late or repeated weaker hit cannot revive a brick.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (erase_enable && e_pos == 6'(i) && active_data > level_q[i])
        level_d[i] = active_data;
    end
  end

  always_comb begin
    blocks_left_d = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (level_q[i] != 2'd3)
        blocks_left_d = blocks_left_d + 4'd1;
    end
    all_cleared_d = (blocks_left_d == 4'd0);
  end

  always_comb begin
    row_hit = 1'b0;
    row_sel = 1'b0;
    col_hit = 1'b0;
    col_sel = '0;
    if (py >= 11'(FIRST_ROW_Y) && py < 11'(FIRST_ROW_Y + BLOCK_HEIGHT)) begin
      row_hit = 1'b1;
    end else if (py >= 11'(SECOND_ROW_Y) && py < 11'(SECOND_ROW_Y + BLOCK_HEIGHT)) begin
      row_hit = 1'b1;
      row_sel = 1'b1;
    end
    for (int c = 0; c < BLOCKS_PER_ROW; c++) begin
      if (px >= 11'(BLOCK_SPACING_X + c * (BLOCK_WIDTH + BLOCK_SPACING_X)) &&
          px <  11'(BLOCK_SPACING_X + c * (BLOCK_WIDTH + BLOCK_SPACING_X) + BLOCK_WIDTH)) begin
        col_hit = 1'b1;
        col_sel = IDX_W'(c);
      end
    end
    s1_idx_d    = row_sel ? col_sel + IDX_W'(BLOCKS_PER_ROW) : col_sel;
    s1_inside_d = row_hit && col_hit && (s1_idx_d < IDX_W'(NUM_BLOCKS));
    s1_video_d  = video_on;
  end

`ifdef HIT_FLASH_EN
  localparam int FL_W = $clog2(FLASH_FRAMES + 1);

  logic [FL_W-1:0] flash_q [NUM_BLOCKS];
  logic [FL_W-1:0] flash_d [NUM_BLOCKS];

  // A level increase reloads the counter even if a frame tick lands on the same edge.
  always_comb begin
    flash_d = flash_q;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (level_d[i] != level_q[i])
        flash_d[i] = FL_W'(FLASH_FRAMES);
      else if (frame_tick && flash_q[i] != '0)
        flash_d[i] = flash_q[i] - FL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) flash_q[i] <= '0;
    end else begin
      flash_q <= flash_d;
    end
  end
`else
  localparam int unused_flash_frames = FLASH_FRAMES;
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
`endif

  // Stage 2 reads the table before this edge's write lands, giving the defined collision order.
  always_comb begin
    rd_level      = level_q[s1_idx_q];
    rgb_d         = 8'h00;
    brick_pixel_d = 1'b0;
    if (s1_video_q && s1_inside_q && rd_level != 2'd3) begin
      brick_pixel_d = 1'b1;
      case (rd_level)
        2'd0:    rgb_d = 8'hE0;
        2'd1:    rgb_d = 8'hFC;
        2'd2:    rgb_d = 8'h1C;
        default: rgb_d = 8'h00;
      endcase
`ifdef HIT_FLASH_EN
      if (flash_q[s1_idx_q] != '0)
        rgb_d = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) level_q[i] <= 2'd0;
      blocks_left_q <= 4'(NUM_BLOCKS);
      all_cleared_q <= 1'b0;
      s1_inside_q   <= 1'b0;
      s1_idx_q      <= '0;
      s1_video_q    <= 1'b0;
      rgb_q         <= 8'h00;
      brick_pixel_q <= 1'b0;
    end else begin
      level_q       <= level_d;
      blocks_left_q <= blocks_left_d;
      all_cleared_q <= all_cleared_d;
      s1_inside_q   <= s1_inside_d;
      s1_idx_q      <= s1_idx_d;
      s1_video_q    <= s1_video_d;
      rgb_q         <= rgb_d;
      brick_pixel_q <= brick_pixel_d;
    end
  end

  assign rgb         = rgb_q;
  assign brick_pixel = brick_pixel_q;
  assign blocks_left = blocks_left_q;
  assign all_cleared = all_cleared_q;

endmodule

// File: tb/tb_brick_field.sv
// Directed self-checking bench for brick_field; expected colours follow HIT_FLASH_EN if defined.
module tb_brick_field;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       erase_enable = 1'b0;
  logic [5:0] e_pos = '0;
  logic [1:0] active_data = '0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       video_on = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] rgb;
  logic       brick_pixel;
  logic [3:0] blocks_left;
  logic       all_cleared;

  int checks = 0;
  int errors = 0;

`ifdef HIT_FLASH_EN
  localparam logic [7:0] HIT1_COLOR = 8'hFF;
  localparam logic [7:0] HIT2_COLOR = 8'hFF;
`else
  localparam logic [7:0] HIT1_COLOR = 8'hFC;
  localparam logic [7:0] HIT2_COLOR = 8'h1C;
`endif

  brick_field dut (
    .clk(clk), .reset(reset), .erase_enable(erase_enable), .e_pos(e_pos),
    .active_data(active_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .rgb(rgb),
    .brick_pixel(brick_pixel), .blocks_left(blocks_left), .all_cleared(all_cleared)
  );

  always #5 clk = ~clk;

  task automatic strobe(input logic [5:0] pos, input logic [1:0] data);
    @(negedge clk);
    erase_enable = 1'b1;
    e_pos        = pos;
    active_data  = data;
    @(negedge clk);
    erase_enable = 1'b0;
  endtask

  task automatic read_pixel(input int x, input int y, input logic vo,
                            output logic [7:0] r, output logic b);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = vo;
    @(posedge clk);
    @(posedge clk);
    #1;
    r = rgb;
    b = brick_pixel;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (blocks_left !== 4'd10 || rgb !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got blocks_left=%0d rgb=%h exp 10 00", blocks_left, rgb);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    logic       b;
    repeat (2) @(negedge clk);
    checks++;
    if (rgb !== 8'h00 || brick_pixel !== 1'b0 || blocks_left !== 4'd10 || all_cleared !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rgb=%h bp=%b left=%0d clr=%b exp 00 0 10 0",
               rgb, brick_pixel, blocks_left, all_cleared);
    end
    reset = 1'b0;
    @(negedge clk);
    pixel_x = 10'd40; pixel_y = 10'd40; video_on = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rgb !== 8'h00) begin
      errors++;
      $display("FAIL latency_1cyc got %h exp 00", rgb);
    end
    @(posedge clk); #1;
    checks++;
    if (rgb !== 8'hE0 || brick_pixel !== 1'b1) begin
      errors++;
      $display("FAIL latency_2cyc got rgb=%h bp=%b exp E0 1", rgb, brick_pixel);
    end
    read_pixel(40, 40, 1'b0, r, b);
    checks++;
    if (r !== 8'h00 || b !== 1'b0) begin
      errors++;
      $display("FAIL video_off got rgb=%h bp=%b exp 00 0", r, b);
    end
  endtask

  task automatic test_geometry();
    int         xs [6] = '{119, 120, 39, 40, 160, 520};
    int         ys [6] = '{69, 40, 40, 70, 90, 119};
    logic [7:0] ex [6] = '{8'hE0, 8'h00, 8'h00, 8'h00, 8'hE0, 8'hE0};
    logic [7:0] r;
    logic       b;
    for (int i = 0; i < 6; i++) begin
      read_pixel(xs[i], ys[i], 1'b1, r, b);
      checks++;
      if (r !== ex[i] || b !== (ex[i] != 8'h00)) begin
        errors++;
        $display("FAIL geometry(%0d,%0d) got rgb=%h bp=%b exp %h", xs[i], ys[i], r, b, ex[i]);
      end
    end
  endtask

  task automatic test_hit_levels();
    logic [7:0] r;
    logic       b;
    strobe(6'd3, 2'd1);
    strobe(6'd3, 2'd0);
    read_pixel(400, 50, 1'b1, r, b);
    checks++;
    if (r !== HIT1_COLOR || b !== 1'b1) begin
      errors++;
      $display("FAIL level1_no_decrease got rgb=%h bp=%b exp %h 1", r, b, HIT1_COLOR);
    end
    strobe(6'd3, 2'd3);
    checks++;
    if (blocks_left !== 4'd10) begin
      errors++;
      $display("FAIL count_latency got %0d exp 10", blocks_left);
    end
    @(posedge clk); #1;
    checks++;
    if (blocks_left !== 4'd9) begin
      errors++;
      $display("FAIL count_after_kill got %0d exp 9", blocks_left);
    end
    read_pixel(400, 50, 1'b1, r, b);
    checks++;
    if (r !== 8'h00 || b !== 1'b0) begin
      errors++;
      $display("FAIL destroyed_blank got rgb=%h bp=%b exp 00 0", r, b);
    end
  endtask

  task automatic test_clear_all();
    logic [7:0] r;
    logic       b;
    for (int i = 0; i < 10; i++) strobe(6'(i), 2'd3);
    checks++;
    if (blocks_left !== 4'd1 || all_cleared !== 1'b0) begin
      errors++;
      $display("FAIL clear_latency got left=%0d clr=%b exp 1 0", blocks_left, all_cleared);
    end
    @(posedge clk); #1;
    checks++;
    if (blocks_left !== 4'd0 || all_cleared !== 1'b1) begin
      errors++;
      $display("FAIL all_cleared got left=%0d clr=%b exp 0 1", blocks_left, all_cleared);
    end
    strobe(6'd12, 2'd0);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (blocks_left !== 4'd0 || all_cleared !== 1'b1) begin
      errors++;
      $display("FAIL bad_epos_cleared got left=%0d clr=%b exp 0 1", blocks_left, all_cleared);
    end
    do_reset();
    strobe(6'd34, 2'd3);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (blocks_left !== 4'd10 || all_cleared !== 1'b0) begin
      errors++;
      $display("FAIL bad_epos_ignored got left=%0d clr=%b exp 10 0", blocks_left, all_cleared);
    end
    read_pixel(280, 40, 1'b1, r, b);
    checks++;
    if (r !== 8'hE0) begin
      errors++;
      $display("FAIL bad_epos_alias got %h exp E0", r);
    end
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    pixel_x = 10'd40; pixel_y = 10'd40; video_on = 1'b1;
    @(negedge clk);
    erase_enable = 1'b1; e_pos = 6'd0; active_data = 2'd2;
    @(posedge clk); #1;
    checks++;
    if (rgb !== 8'hE0) begin
      errors++;
      $display("FAIL collision_old got %h exp E0", rgb);
    end
    @(negedge clk);
    erase_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rgb !== HIT2_COLOR) begin
      errors++;
      $display("FAIL collision_new got %h exp %h", rgb, HIT2_COLOR);
    end
  endtask

  task automatic test_flash();
    logic [7:0] r;
    logic       b;
    do_reset();
    strobe(6'd0, 2'd1);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (t == 7 || t == 8) begin
        read_pixel(40, 40, 1'b1, r, b);
        checks++;
`ifdef HIT_FLASH_EN
        if (r !== ((t == 8) ? 8'hFC : 8'hFF)) begin
          errors++;
          $display("FAIL flash_tick%0d got %h exp %h", t, r, (t == 8) ? 8'hFC : 8'hFF);
        end
`else
        if (r !== 8'hFC) begin
          errors++;
          $display("FAIL no_flash_tick%0d got %h exp FC", t, r);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_hit_levels();
    test_clear_all();
    test_collision();
    test_flash();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brick_field.md
Name: brick_field

Overview:
- Consumer end of the ball's block-hit interface.
- Latches per-block hit events (erase_enable / e_pos / active_data) into a hit-level table and keeps a remaining-block count.
- Renders the two-row brick wall for the VGA pixel stream: pixel coordinates in, 8-bit RGB332 colour out, through a 2-stage pipeline.
- Sits between the ball logic and the top-level video mux.

Parameters:
NUM_BLOCKS, 10, number of bricks; index 0..NUM_BLOCKS-1
BLOCKS_PER_ROW, 5, bricks per row; index < 5 is row 0, else row 1
BLOCK_SPACING_X, 40, left margin and horizontal gap, in pixels
BLOCK_WIDTH, 80, brick width, in pixels
BLOCK_HEIGHT, 30, brick height, in pixels
FIRST_ROW_Y, 40, top y of row 0
SECOND_ROW_Y, 90, top y of row 1
FLASH_FRAMES, 8, flash duration in frames (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
erase_enable  input  1  one-cycle hit strobe
e_pos  input  6  index of the brick that was hit
active_data  input  2  new hit level of that brick (3 = destroyed)
pixel_x  input  10  current pixel column
pixel_y  input  10  current pixel row
video_on  input  1  pixel is in the visible area
frame_tick  input  1  one-cycle pulse per frame
rgb  output  8  RGB332 brick colour; 0 when no brick
brick_pixel  output  1  rgb carries a drawn brick pixel
blocks_left  output  4  count of bricks with level < 3
all_cleared  output  1  blocks_left == 0

Behaviour:
- Reset, asynchronous:
  - all levels = 0; both pipeline stages invalid
  - rgb = 8'h00, brick_pixel = 0
  - blocks_left = NUM_BLOCKS, all_cleared = 0
  - reset asserted mid-frame or mid-event discards everything in flight; the first output after deassert is 2 cycles after the first sampled pixel.
- Hit table write:
  - A write occurs on a clk edge with erase_enable=1 and e_pos < NUM_BLOCKS.
  - level[e_pos] <= max(level[e_pos], active_data): levels never decrease, saturate at 3.
  - e_pos >= NUM_BLOCKS: strobe ignored, no state change.
  - At most one write per cycle.
- Counters:
  - blocks_left and all_cleared are registered; they reflect a write on the edge after the write edge (1-cycle latency).
  - blocks_left is never below 0 and never above NUM_BLOCKS.
- Geometry, inclusive left/top, exclusive right/bottom:
  - col c = 0..4: x in [BLOCK_SPACING_X + c*(BLOCK_WIDTH+BLOCK_SPACING_X), that + BLOCK_WIDTH)
  - row 0: y in [FIRST_ROW_Y, FIRST_ROW_Y+BLOCK_HEIGHT); row 1 likewise from SECOND_ROW_Y
  - index = row*BLOCKS_PER_ROW + col
  - compute in 11 bits so sums cannot wrap.
- Pipeline, fixed latency 2 cycles, no stalls:
  - Stage 1 registers inside flag, index and video_on.
  - Stage 2 reads the level and registers rgb and brick_pixel.
- Colour map:
  - level 0 = 8'hE0 (red), level 1 = 8'hFC (yellow), level 2 = 8'h1C (green)
  - level 3, outside any brick, or video_on=0 → rgb = 8'h00, brick_pixel = 0.
- Read/write collision: the stage-2 read uses the table value before that edge's update. A write is visible to pixels whose stage-2 edge is strictly after the write edge.
- pixel_x/pixel_y outside 0..639 / 0..479 need no special handling: geometry rejects them.

Optional Feature:
HIT_FLASH_EN
- Defined:
  - Each brick has a flash counter (width $clog2(FLASH_FRAMES+1)), reset 0.
  - A write that increases the level loads FLASH_FRAMES.
  - Counter decrements on frame_tick while nonzero.
  - While nonzero and level < 3, brick pixels output 8'hFF.
  - A load on the same edge as frame_tick wins the decrement.
  - Reaching level 3 blanks the brick immediately, with no flash.
- Undefined: no counters are built, frame_tick is ignored, and the colour map is as above.

Test Plan:
1. Reset release, then pixel (40,40) with video_on=1 → rgb=8'hE0, brick_pixel=1 exactly 2 cycles later; blocks_left=10, all_cleared=0.
2. Edge pixels: (119,69) → 8'hE0. (120,40), (39,40), (40,70) → 8'h00. (160,90) → index 6 → 8'hE0.
3. Strobe e_pos=3, active_data=1, then e_pos=3, active_data=0:
   - pixel (400,50) → 8'hFC; the level stays 1 after the second strobe.
   - Then active_data=3 → 8'h00, and blocks_left=9 one cycle after the write.
4. Write level 3 to all 10 bricks:
   - all_cleared=1 the cycle after the last write.
   - e_pos=12 strobe → no change; reset → blocks_left=10.
5. Collision: drive pixel (40,40) and, one cycle later, strobe e_pos=0, active_data=2 on the stage-2 edge → that output is 8'hE0; the next pixel at (40,40) → 8'h1C.
6. HIT_FLASH_EN, FLASH_FRAMES=8: hit e_pos=0 to level 1 → brick pixels 8'hFF for 8 frame_ticks, then 8'hFC. Without the macro: 8'hFC immediately.
